control_unit: RTL and testbench

Hardwired Moore sequencer that drives every datapath control input the benches previously toggled by hand. It sits beside `datapath` and reads the latched instruction (`IR`). It emits `BusDataSelect`, register enables, RAM strobes and `ALU_op` to run fetch and a subset of the Mini SRC ISA. It stops at `halt`.

---
 rtl/control_unit_if.sv | 42 ++++
 rtl/control_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_control_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if: instruction input and all datapath control outputs of
// control_unit, bundled for connection between sequencer and datapath.
interface control_unit_if;
  logic [31:0] IR;
  logic        e_PC;
  logic        incPC;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_MDR;
  logic        e_MAR;
  logic        e_RA;
  logic        ram_read;
  logic        ram_write;
  logic        MDR_read;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        e_Rin;
  logic        e_Rout;
  logic        BAout;
  logic        imm_sel;
  logic        run;

  // Sequencer side: reads IR, drives every control line.
  modport master (
    input  IR,
    output e_PC, incPC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_RA,
    output ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
    output Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, run
  );

  // Datapath side: supplies IR, consumes the control lines.
  modport slave (
    output IR,
    input  e_PC, incPC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_RA,
    input  ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
    input  Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel, run
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for fetch and a Mini SRC subset.
// Optional macro CU_JUMP_EN enables jr/jal; without it those opcodes act as nop.
// RAM_WAIT (0..3) idle cycles follow each MAR load before the RAM strobe.
module control_unit #(
  parameter int unsigned RAM_WAIT = 1
) (
  input  logic           clock,
  input  logic           clear,
  control_unit_if.master bus
);

  typedef enum logic [4:0] {
    S_RST, S_F0, S_FW, S_F1, S_F1W, S_F2, S_T3,
    S_ALU4, S_ALU5, S_IMM4, S_IMM5, S_MEM5,
    S_LDW, S_LD6, S_LD6W, S_LD7,
    S_ST6, S_STW, S_ST7,
`ifdef CU_JUMP_EN
    S_JAL4,
`endif
    S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011;
`ifdef CU_JUMP_EN
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_JAL  = 5'b10110;
`endif

  localparam logic [4:0] SEL_PC  = 5'b10100;
  localparam logic [4:0] SEL_MDR = 5'b10101;
  localparam logic [4:0] SEL_Z   = 5'b10011;

  localparam bit         SKIP_WAIT = (RAM_WAIT == 0);
  // Counter loads RAM_WAIT-1 so the wait state lasts exactly RAM_WAIT cycles.
  localparam logic [1:0] WAIT_LOAD = SKIP_WAIT ? 2'd0 : 2'(RAM_WAIT - 1);

  state_t     state, next_state;
  logic [4:0] op_q;
  logic [1:0] wait_cnt;
  logic [4:0] opcode;
  logic       is_alu;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign is_alu    = (opcode >= 5'b00011) && (opcode <= 5'b01010);
  assign unused_ir = ^bus.IR[26:0];

  // State register; clear forces RST without waiting for a clock.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_RST;
    else        state <= next_state;
  end

  // Opcode captured during T3 so later execute states ignore IR changes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)              op_q <= '0;
    else if (state == S_T3)  op_q <= opcode;
  end

  // Wait counter: reload on entry to a wait state, count down while waiting.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wait_cnt <= '0;
    end else if ((next_state != state) &&
                 ((next_state == S_FW) || (next_state == S_LDW) || (next_state == S_STW))) begin
      wait_cnt <= WAIT_LOAD;
    end else if (wait_cnt != 2'd0) begin
      wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_RST:  next_state = S_F0;
      S_F0:   next_state = SKIP_WAIT ? S_F1 : S_FW;
      S_FW:   next_state = (wait_cnt == 2'd0) ? S_F1 : S_FW;
      S_F1:   next_state = S_F1W;
      S_F1W:  next_state = S_F2;
      S_F2:   next_state = S_T3;
      S_T3: begin
        if (is_alu) begin
          next_state = S_ALU4;
        end else begin
          case (opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADDI: next_state = S_IMM4;
`ifdef CU_JUMP_EN
            OP_JAL:                        next_state = S_JAL4;
`endif
            OP_HALT:                       next_state = S_HALT;
            default:                       next_state = S_F0;
          endcase
        end
      end
      S_ALU4: next_state = S_ALU5;
      S_ALU5: next_state = S_F0;
      S_IMM4: next_state = ((op_q == OP_LD) || (op_q == OP_ST)) ? S_MEM5 : S_IMM5;
      S_IMM5: next_state = S_F0;
      S_MEM5: begin
        if (op_q == OP_ST) next_state = S_ST6;
        else               next_state = SKIP_WAIT ? S_LD6 : S_LDW;
      end
      S_LDW:  next_state = (wait_cnt == 2'd0) ? S_LD6 : S_LDW;
      S_LD6:  next_state = S_LD6W;
      S_LD6W: next_state = S_LD7;
      S_LD7:  next_state = S_F0;
      S_ST6:  next_state = SKIP_WAIT ? S_ST7 : S_STW;
      S_STW:  next_state = (wait_cnt == 2'd0) ? S_ST7 : S_STW;
      S_ST7:  next_state = S_F0;
`ifdef CU_JUMP_EN
      S_JAL4: next_state = S_F0;
`endif
      S_HALT: next_state = S_HALT;
      default: next_state = S_RST;
    endcase
  end

  // Output decode; T3 also looks at the freshly loaded IR since IR only
  // becomes valid in that state.
  always_comb begin
    bus.e_PC          = 1'b0;
    bus.incPC         = 1'b0;
    bus.e_IR          = 1'b0;
    bus.e_Y           = 1'b0;
    bus.e_Z           = 1'b0;
    bus.e_MDR         = 1'b0;
    bus.e_MAR         = 1'b0;
    bus.e_RA          = 1'b0;
    bus.ram_read      = 1'b0;
    bus.ram_write     = 1'b0;
    bus.MDR_read      = 1'b0;
    bus.ALU_op        = 4'b0000;
    bus.BusDataSelect = 5'b00000;
    bus.Gra           = 1'b0;
    bus.Grb           = 1'b0;
    bus.Grc           = 1'b0;
    bus.e_Rin         = 1'b0;
    bus.e_Rout        = 1'b0;
    bus.BAout         = 1'b0;
    bus.imm_sel       = 1'b0;
    bus.run           = (state != S_RST) && (state != S_HALT);
    case (state)
      S_F0: begin
        bus.BusDataSelect = SEL_PC;
        bus.e_MAR         = 1'b1;
        bus.incPC         = 1'b1;
      end
      S_F1:  bus.ram_read = 1'b1;
      S_F1W: begin
        bus.MDR_read = 1'b1;
        bus.e_MDR    = 1'b1;
      end
      S_F2: begin
        bus.BusDataSelect = SEL_MDR;
        bus.e_IR          = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          bus.Grb    = 1'b1;
          bus.e_Rout = 1'b1;
          bus.e_Y    = 1'b1;
        end else begin
          case (opcode)
            OP_LD, OP_LDI, OP_ST: begin
              bus.Grb   = 1'b1;
              bus.BAout = 1'b1;
              bus.e_Y   = 1'b1;
            end
            OP_ADDI: begin
              bus.Grb    = 1'b1;
              bus.e_Rout = 1'b1;
              bus.e_Y    = 1'b1;
            end
`ifdef CU_JUMP_EN
            OP_JR: begin
              bus.Gra    = 1'b1;
              bus.e_Rout = 1'b1;
              bus.e_PC   = 1'b1;
            end
            OP_JAL: begin
              bus.BusDataSelect = SEL_PC;
              bus.e_RA          = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      S_ALU4: begin
        bus.Grc    = 1'b1;
        bus.e_Rout = 1'b1;
        bus.ALU_op = op_q[3:0];
        bus.e_Z    = 1'b1;
      end
      S_ALU5, S_IMM5: begin
        bus.BusDataSelect = SEL_Z;
        bus.Gra           = 1'b1;
        bus.e_Rin         = 1'b1;
      end
      S_IMM4: begin
        bus.imm_sel = 1'b1;
        bus.ALU_op  = 4'b0011;
        bus.e_Z     = 1'b1;
      end
      S_MEM5: begin
        bus.BusDataSelect = SEL_Z;
        bus.e_MAR         = 1'b1;
      end
      S_LD6:  bus.ram_read = 1'b1;
      S_LD6W: begin
        bus.MDR_read = 1'b1;
        bus.e_MDR    = 1'b1;
      end
      S_LD7: begin
        bus.BusDataSelect = SEL_MDR;
        bus.Gra           = 1'b1;
        bus.e_Rin         = 1'b1;
      end
      S_ST6: begin
        bus.Gra    = 1'b1;
        bus.e_Rout = 1'b1;
        bus.e_MDR  = 1'b1;
      end
      S_ST7: bus.ram_write = 1'b1;
`ifdef CU_JUMP_EN
      S_JAL4: begin
        bus.Gra    = 1'b1;
        bus.e_Rout = 1'b1;
        bus.e_PC   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed cycle-by-cycle checks of control_unit outputs
// at RAM_WAIT=1 (main instance) and RAM_WAIT=0 (second instance, st only).
module tb_control_unit;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  control_unit_if bus1();
  control_unit_if bus0();

  control_unit #(.RAM_WAIT(1)) u_dut1 (.clock(clock), .clear(clear), .bus(bus1));
  control_unit #(.RAM_WAIT(0)) u_dut0 (.clock(clock), .clear(clear), .bus(bus0));

  logic [27:0] obs1, obs0;
  assign obs1 = {bus1.run, bus1.BusDataSelect, bus1.ALU_op, bus1.e_PC, bus1.incPC,
                 bus1.e_IR, bus1.e_Y, bus1.e_Z, bus1.e_MDR, bus1.e_MAR, bus1.e_RA,
                 bus1.ram_read, bus1.ram_write, bus1.MDR_read, bus1.Gra, bus1.Grb,
                 bus1.Grc, bus1.e_Rin, bus1.e_Rout, bus1.BAout, bus1.imm_sel};
  assign obs0 = {bus0.run, bus0.BusDataSelect, bus0.ALU_op, bus0.e_PC, bus0.incPC,
                 bus0.e_IR, bus0.e_Y, bus0.e_Z, bus0.e_MDR, bus0.e_MAR, bus0.e_RA,
                 bus0.ram_read, bus0.ram_write, bus0.MDR_read, bus0.Gra, bus0.Grb,
                 bus0.Grc, bus0.e_Rin, bus0.e_Rout, bus0.BAout, bus0.imm_sel};

  localparam logic [27:0] IMM    = 28'd1 << 0;
  localparam logic [27:0] BAOUT  = 28'd1 << 1;
  localparam logic [27:0] EROUT  = 28'd1 << 2;
  localparam logic [27:0] ERIN   = 28'd1 << 3;
  localparam logic [27:0] GRC    = 28'd1 << 4;
  localparam logic [27:0] GRB    = 28'd1 << 5;
  localparam logic [27:0] GRA    = 28'd1 << 6;
  localparam logic [27:0] MDRRD  = 28'd1 << 7;
  localparam logic [27:0] RAMWR  = 28'd1 << 8;
  localparam logic [27:0] RAMRD  = 28'd1 << 9;
  localparam logic [27:0] ERA    = 28'd1 << 10;
  localparam logic [27:0] EMAR   = 28'd1 << 11;
  localparam logic [27:0] EMDR   = 28'd1 << 12;
  localparam logic [27:0] EZ     = 28'd1 << 13;
  localparam logic [27:0] EY     = 28'd1 << 14;
  localparam logic [27:0] EIR    = 28'd1 << 15;
  localparam logic [27:0] INCPC  = 28'd1 << 16;
  localparam logic [27:0] EPC    = 28'd1 << 17;
  localparam logic [27:0] RUN    = 28'd1 << 27;
  localparam logic [27:0] B_PC   = 28'(5'b10100) << 22;
  localparam logic [27:0] B_MDR  = 28'(5'b10101) << 22;
  localparam logic [27:0] B_Z    = 28'(5'b10011) << 22;

  localparam logic [31:0] I_LDI  = 32'h0A000078;
  localparam logic [31:0] I_SUB  = 32'h22000000;
  localparam logic [31:0] I_ADDI = 32'h60000000;
  localparam logic [31:0] I_LD   = 32'h00000000;
  localparam logic [31:0] I_ST   = 32'h12000000;
  localparam logic [31:0] I_JR   = 32'hA8000000;
  localparam logic [31:0] I_JAL  = 32'hB0000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_UND  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  function automatic logic [27:0] alu(input logic [3:0] x);
    return {6'b0, x, 18'b0};
  endfunction

  task automatic check(input logic [27:0] obs, input logic [27:0] exp, input string tag);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic chk1(input logic [27:0] exp, input string tag);
    check(obs1, exp, tag);
    @(negedge clock);
  endtask

  task automatic chk0(input logic [27:0] exp, input string tag);
    check(obs0, exp, tag);
    @(negedge clock);
  endtask

  task automatic fetch1();
    chk1(RUN | B_PC | EMAR | INCPC, "f0");
    chk1(RUN,                       "fw");
    chk1(RUN | RAMRD,               "f1");
    chk1(RUN | MDRRD | EMDR,        "f1w");
    chk1(RUN | B_MDR | EIR,         "f2");
  endtask

  initial begin
    bus1.IR = I_LD;
    bus0.IR = I_ST;

    // reset held for three cycles
    check(obs0, '0, "reset_dut0");
    repeat (3) chk1('0, "reset");
    clear = 1'b1;
    @(negedge clock);

    // ldi R4,0x78
    bus1.IR = I_LDI;
    fetch1();
    chk1(RUN | GRB | BAOUT | EY,      "ldi_t3");
    chk1(RUN | IMM | alu(4'b0011) | EZ, "ldi_t4");
    chk1(RUN | B_Z | GRA | ERIN,      "ldi_t5");

    // sub; IR changes after T3 must not disturb execution
    bus1.IR = I_SUB;
    fetch1();
    chk1(RUN | GRB | EROUT | EY,      "sub_t3");
    bus1.IR = I_HALT;
    chk1(RUN | GRC | EROUT | alu(4'b0100) | EZ, "sub_t4");
    chk1(RUN | B_Z | GRA | ERIN,      "sub_t5");

    // addi
    bus1.IR = I_ADDI;
    fetch1();
    chk1(RUN | GRB | EROUT | EY,      "addi_t3");
    chk1(RUN | IMM | alu(4'b0011) | EZ, "addi_t4");
    chk1(RUN | B_Z | GRA | ERIN,      "addi_t5");

    // ld
    bus1.IR = I_LD;
    fetch1();
    chk1(RUN | GRB | BAOUT | EY,      "ld_t3");
    chk1(RUN | IMM | alu(4'b0011) | EZ, "ld_t4");
    chk1(RUN | B_Z | EMAR,            "ld_t5");
    chk1(RUN,                         "ld_wait");
    chk1(RUN | RAMRD,                 "ld_t6");
    chk1(RUN | MDRRD | EMDR,          "ld_t6w");
    chk1(RUN | B_MDR | GRA | ERIN,    "ld_t7");

    // st
    bus1.IR = I_ST;
    fetch1();
    chk1(RUN | GRB | BAOUT | EY,      "st_t3");
    chk1(RUN | IMM | alu(4'b0011) | EZ, "st_t4");
    chk1(RUN | B_Z | EMAR,            "st_t5");
    chk1(RUN | GRA | EROUT | EMDR,    "st_t6");
    chk1(RUN,                         "st_wait");
    chk1(RUN | RAMWR,                 "st_t7");

    // jr / jal
    bus1.IR = I_JR;
    fetch1();
`ifdef CU_JUMP_EN
    chk1(RUN | GRA | EROUT | EPC,     "jr_t3");
`else
    chk1(RUN,                         "jr_as_nop");
`endif
    bus1.IR = I_JAL;
    fetch1();
`ifdef CU_JUMP_EN
    chk1(RUN | B_PC | ERA,            "jal_t3");
    chk1(RUN | GRA | EROUT | EPC,     "jal_t4");
`else
    chk1(RUN,                         "jal_as_nop");
`endif

    // nop and an undefined opcode
    bus1.IR = I_NOP;
    fetch1();
    chk1(RUN,                         "nop_t3");
    bus1.IR = I_UND;
    fetch1();
    chk1(RUN,                         "undef_t3");

    // halt is absorbing
    bus1.IR = I_HALT;
    fetch1();
    chk1(RUN,                         "halt_t3");
    repeat (20) chk1('0,              "halt_hold");

    // clear exits halt through RST
    clear = 1'b0;
    #1 check(obs1, '0,                "halt_clear");
    @(negedge clock);
    check(obs1, '0,                   "rst_state");
    clear = 1'b1;
    @(negedge clock);

    // clear asserted during st T6 kills the write immediately
    bus1.IR = I_ST;
    fetch1();
    chk1(RUN | GRB | BAOUT | EY,      "st2_t3");
    chk1(RUN | IMM | alu(4'b0011) | EZ, "st2_t4");
    chk1(RUN | B_Z | EMAR,            "st2_t5");
    check(obs1, RUN | GRA | EROUT | EMDR, "st2_t6");
    #2 clear = 1'b0;
    #1 check(obs1, '0,                "st2_async_clear");
    @(negedge clock);
    repeat (2) chk1('0,               "st2_no_write");
    clear = 1'b1;
    @(negedge clock);

    // RAM_WAIT=0 instance running st from reset
    chk0(RUN | B_PC | EMAR | INCPC,   "w0_f0");
    chk0(RUN | RAMRD,                 "w0_f1");
    chk0(RUN | MDRRD | EMDR,          "w0_f1w");
    chk0(RUN | B_MDR | EIR,           "w0_f2");
    chk0(RUN | GRB | BAOUT | EY,      "w0_st_t3");
    chk0(RUN | IMM | alu(4'b0011) | EZ, "w0_st_t4");
    chk0(RUN | B_Z | EMAR,            "w0_st_t5");
    chk0(RUN | GRA | EROUT | EMDR,    "w0_st_t6");
    chk0(RUN | RAMWR,                 "w0_st_t7");
    chk0(RUN | B_PC | EMAR | INCPC,   "w0_f0_again");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
